// File: rtl/tbus_pkg.sv
// rtl/tbus_pkg.sv - shared FSM states and counter widths for the tristate bus arbiter
package tbus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Wide enough for HOLD_MAX up to 255 and TURNAROUND up to 7
    localparam int HOLD_W = 8;
    localparam int TURN_W = 3;

endpackage

// File: rtl/tbus_arbiter_if.sv
// rtl/tbus_arbiter_if.sv - request/grant/enable bundle between requesters and the arbiter
interface tbus_arbiter_if #(
    parameter int N = 4
);
    localparam int OW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [N-1:0]  en;
    logic          busy;
    logic [OW-1:0] owner;

    modport master (
        input  req,
        output gnt,
        output en,
        output busy,
        output owner
    );

    modport slave (
        output req,
        input  gnt,
        input  en,
        input  busy,
        input  owner
    );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search upward from ptr with wrap
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);
    int k;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        k      = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!valid && req[k]) begin
                winner[k] = 1'b1;
                valid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tbus_arbiter.sv
// rtl/tbus_arbiter.sv - round-robin tristate bus arbiter with tenure limit and turnaround gap
module tbus_arbiter
    import tbus_pkg::*;
#(
    parameter int N          = 4,
    parameter int HOLD_MAX   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic          clk,
    input  logic          rst,
    tbus_arbiter_if.master bus
);
    localparam int OW = $clog2(N);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
    localparam logic [TURN_W-1:0] TURN_LIM = TURN_W'(TURNAROUND);
    localparam logic [OW-1:0]     LAST     = OW'(N - 1);

    state_t              state_q, state_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic [N-1:0]        en_q;
    logic                busy_q;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       ptr_q, ptr_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [TURN_W-1:0]   tcnt_q, tcnt_d;

    logic [N-1:0]        pick;
    logic                pick_valid;
    logic [OW-1:0]       pick_idx;
    logic                grant_now;

    rr_pick #(.N(N), .PW(OW)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (pick),
        .valid  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) pick_idx = OW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        grant_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) grant_now = 1'b1;
            end
            GRANT: begin
                // Release on owner drop, or pre-empt once tenure is exhausted and someone else waits
                if (!bus.req[owner_q] ||
                    (cnt_q == HOLD_LIM && |(bus.req & ~gnt_q))) begin
                    gnt_d   = '0;
                    tcnt_d  = TURN_W'(1);
                    state_d = TURN;
                end else if (cnt_q != HOLD_LIM) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TURN: begin
                if (tcnt_q == TURN_LIM) begin
                    if (pick_valid) grant_now = 1'b1;
                    else            state_d   = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (grant_now) begin
            gnt_d   = pick;
            owner_d = pick_idx;
            ptr_d   = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
            cnt_d   = HOLD_W'(1);
            state_d = GRANT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            en_q    <= gnt_d;
            busy_q  <= |gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.en    = en_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;
endmodule

// File: doc/tbus_arbiter.md
TBUS_ARBITER -- requirements
Module: tbus_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one tristate bus; legal range 2..16.
REQ-002 Parameter HOLD_MAX, default 8: maximum grant tenure in cycles while other requests are pending; legal range 1..255.
REQ-003 Parameter TURNAROUND, default 1: number of all-drivers-off cycles between two owners; legal range 1..7.
REQ-004 CLK  input  1  the single clock; all state changes on the rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 REQ  input  N  per-requester bus request, level-sensitive, held while bus wanted.
REQ-007 GNT  output  N  one-hot grant to the owning requester.
REQ-008 EN  output  N  tbuf enable per requester driver; all-zero means the bus is high-Z.
REQ-009 BUSY  output  1  high while any GNT bit is high.
REQ-010 OWNER  output  clog2(N)  index of the current or last owner.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and TURN.
REQ-012 GNT, EN, BUSY and OWNER SHALL all be registered outputs, and EN SHALL equal GNT bit-for-bit every cycle.
REQ-013 GNT SHALL never have more than one bit set.
REQ-014 Arbitration SHALL be round-robin, searching upward with wrap from pointer PTR; PTR SHALL become owner+1 mod N on each grant.
REQ-015 In IDLE with REQ nonzero at an edge, the arbiter SHALL set GNT to the winner on that edge and enter GRANT; grant latency is 1 cycle and tenure count = 1.
REQ-016 In GRANT, the tenure count SHALL increment each cycle and saturate at HOLD_MAX.
REQ-017 In GRANT, REQ[OWNER]=0 sampled at an edge SHALL clear GNT on that edge and enter TURN.
REQ-018 In GRANT with count = HOLD_MAX and any other REQ bit set, the arbiter SHALL clear GNT and enter TURN (pre-emption).
REQ-019 In GRANT with count = HOLD_MAX and no other request, the owner SHALL keep the grant.
REQ-020 TURN SHALL last exactly TURNAROUND cycles with GNT = EN = 0.
REQ-021 In the last TURN cycle, the arbiter SHALL arbitrate the current REQ: if nonzero, the winner is granted on the exiting edge; otherwise the FSM enters IDLE.
REQ-022 A pre-empted owner that still requests SHALL be eligible only by round-robin order and SHALL win immediately again only if it is the sole requester.
REQ-023 Requests that rise or fall during TURN SHALL affect only the final-cycle arbitration.
REQ-024 No cycle SHALL exist in which EN bits for two different owners are high; one owner's GNT falling and the next owner's GNT rising in the same cycle is forbidden.
REQ-025 OWNER SHALL update on each grant and hold its value through TURN and IDLE.

Reset
REQ-026 Asserting RESET SHALL immediately and asynchronously force GNT=0, EN=0, BUSY=0, OWNER=0, PTR=0, count=0 and state IDLE.
REQ-027 Reset asserted mid-tenure or mid-TURN SHALL drop the bus to high-Z without waiting for a clock edge.
REQ-028 After RESET is released, the first arbitration SHALL start from PTR=0.

Structure
REQ-029 A shared package tbus_pkg SHALL hold the state enumeration and the TURNAROUND and HOLD_MAX counter-width constants.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_pick with inputs REQ and PTR and outputs a one-hot winner and a valid flag.

Verification (N=4, HOLD_MAX=4, TURNAROUND=1)
REQ-031 REQ=0001 from IDLE -> GNT=0001 one cycle later; REQ dropped -> GNT=0 for 1 cycle, then IDLE.
REQ-032 REQ=1111 held -> grants go 0001, 0010, 0100, 1000, 0001, each 4 cycles long with a 1-cycle zero gap between them.
REQ-033 REQ=0100 held alone for 20 cycles -> GNT=0100 continuously, with no pre-emption gap.
REQ-034 Owner 0 granted, REQ=0011 at count=4 -> TURN, then GNT=0010, OWNER=1, PTR=2.
REQ-035 RESET pulsed mid-tenure between clock edges -> EN=0000 immediately; after release, REQ=1010 -> GNT=0010.
REQ-036 Random REQ for 10k cycles -> checker confirms $onehot0(EN), a turnaround gap on every owner change, and no requester starved beyond (N-1)*(HOLD_MAX+TURNAROUND) cycles.
